// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage multi-cycle data memory access controller.
package mem_access_ctrl_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data memory bus between the access controller (master) and the multi-cycle memory (slave).
interface mem_access_ctrl_if;
  import mem_access_ctrl_pkg::*;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [DATA_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_ack_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_ack_i, mem_rdata_i
  );

endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: stalls the pipeline while a load/store completes on a multi-cycle memory.
// Optional macro MEM_ACCESS_TIMEOUT_EN aborts a request after TIMEOUT_CYCLES WAIT cycles and sets err_o.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [DATA_W-1:0] ALUResult_i,
  input  logic [DATA_W-1:0] MemWriteData_i,
  mem_access_ctrl_if.master mem,
  output logic              stall_o,
  output logic [DATA_W-1:0] ReadData_o,
  output logic              ReadValid_o,
  output logic              err_o
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("mem_access_ctrl: TIMEOUT_CYCLES must be in 2..255");
  end

  state_e            state_q;
  logic              req_q;
  logic              we_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;
  logic              access;

  assign access = MemRead_i | MemWrite_i;

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt_q;
  logic       err_q;
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      rvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (access) begin
            // A simultaneous read and write request is issued as a write.
            addr_q  <= ALUResult_i;
            wdata_q <= MemWriteData_i;
            we_q    <= MemWrite_i;
            req_q   <= 1'b1;
            state_q <= WAIT;
`ifdef MEM_ACCESS_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        WAIT: begin
          if (mem.mem_ack_i) begin
            req_q   <= 1'b0;
            state_q <= DONE;
            if (!we_q) begin
              rdata_q  <= mem.mem_rdata_i;
              rvalid_q <= 1'b1;
            end
          end
`ifdef MEM_ACCESS_TIMEOUT_EN
          else if (cnt_q == TIMEOUT_LAST) begin
            // Abort: a timed-out load still completes, returning zero data.
            req_q   <= 1'b0;
            err_q   <= 1'b1;
            state_q <= DONE;
            if (!we_q) begin
              rdata_q  <= '0;
              rvalid_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
`endif
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  // The request cycle itself stalls so EX/MEM holds until DONE lets it advance once.
  always_comb begin
    stall_o = 1'b0;
    if (!rst_i) begin
      stall_o = (state_q == WAIT) || ((state_q == IDLE) && access);
    end
  end

  assign mem.mem_req_o   = req_q;
  assign mem.mem_we_o    = we_q;
  assign mem.mem_addr_o  = addr_q;
  assign mem.mem_wdata_o = wdata_q;
  assign ReadData_o      = rdata_q;
  assign ReadValid_o     = rvalid_q;

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: number of WAIT cycles without ack before abort; legal range 2..255.
REQ-002 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 MemRead_i  input  1  MEM-stage load request, from the EX/MEM pipeline register.
REQ-005 MemWrite_i  input  1  MEM-stage store request, from the EX/MEM pipeline register.
REQ-006 ALUResult_i  input  32  byte address of the access.
REQ-007 MemWriteData_i  input  32  store data (RS2Data).
REQ-008 mem_req_o  output  1  request to multi-cycle data memory.
REQ-009 mem_we_o  output  1  1 = write, 0 = read; valid while mem_req_o = 1.
REQ-010 mem_addr_o  output  32  latched address.
REQ-011 mem_wdata_o  output  32  latched store data.
REQ-012 mem_ack_i  input  1  memory completion, one-cycle pulse.
REQ-013 mem_rdata_i  input  32  read data, valid with mem_ack_i.
REQ-014 stall_o  output  1  freezes PC, IF/ID, ID/EX and EX/MEM registers.
REQ-015 ReadData_o  output  32  load result for MEM/WB.
REQ-016 ReadValid_o  output  1  one-cycle pulse: ReadData_o holds a new load result.
REQ-017 err_o  output  1  sticky timeout flag.

Function
REQ-018 The FSM SHALL have states IDLE, WAIT and DONE.
REQ-019 IDLE, MemRead_i|MemWrite_i = 1: latch address, data and we (we = MemWrite_i); go to WAIT; stall_o = 1 combinationally in this cycle.
REQ-020 IDLE, no access: stay in IDLE; stall_o = 0; mem_req_o = 0.
REQ-021 WAIT: mem_req_o = 1 (registered); address, data and we held stable; stall_o = 1.
REQ-022 WAIT, mem_ack_i = 1: go to DONE; on a read, ReadData_o <= mem_rdata_i.
REQ-023 DONE: mem_req_o = 0; stall_o = 0 so the pipeline advances exactly once; ReadValid_o = 1 only if the access was a read; next state IDLE.
REQ-024 Zero-wait memory (ack in the first WAIT cycle) SHALL give exactly 2 stall cycles per access; each extra wait cycle adds 1.
REQ-025 MemRead_i and MemWrite_i both 1: treated as a write; ReadValid_o stays 0.
REQ-026 mem_ack_i in IDLE or DONE SHALL be ignored.
REQ-027 Input changes during WAIT SHALL NOT affect the latched request.
REQ-028 ReadData_o SHALL hold its value until the next completed read.

Reset
REQ-029 When rst_i = 1 at a clock edge: state = IDLE; mem_req_o = 0; mem_we_o = 0; mem_addr_o = 0; mem_wdata_o = 0; ReadData_o = 0; ReadValid_o = 0; err_o = 0.
REQ-030 stall_o SHALL be 0 while rst_i = 1.
REQ-031 Reset during WAIT SHALL abandon the access and drop mem_req_o at that edge; a later mem_ack_i SHALL be ignored per REQ-026.

Configuration
REQ-032 Macro MEM_ACCESS_TIMEOUT_EN defined: an 8-bit counter, cleared on entry to WAIT, counts WAIT cycles.
REQ-033 Counter reaching TIMEOUT_CYCLES with no ack: go to DONE; set err_o (sticky until reset); on a read, ReadData_o = 0 and ReadValid_o pulses.
REQ-034 Macro MEM_ACCESS_TIMEOUT_EN undefined: no counter; WAIT lasts until ack; err_o tied to 0.

Structure
REQ-035 Shared package SHALL hold the state encoding (IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2) and the 32-bit data/address width constant.
REQ-036 No sub-module; the timeout counter is inline, inside the macro guard.

Verification
REQ-037 Load at 0x40, ack in the first WAIT cycle with rdata 0xDEADBEEF -> stall_o high for 2 cycles; ReadData_o = 0xDEADBEEF; ReadValid_o pulses in DONE.
REQ-038 Store 0x12345678 to 0x80, ack after 3 WAIT cycles -> mem_we_o = 1; address and data stable throughout; 4 stall cycles; ReadValid_o stays 0.
REQ-039 Back-to-back load then store -> DONE, IDLE, WAIT sequence; one pipeline advance per access; no request is dropped.
REQ-040 rst_i asserted in the 2nd WAIT cycle, ack arrives one cycle later -> mem_req_o = 0 after the edge; ack ignored; err_o = 0; ReadValid_o = 0.
REQ-041 MEM_ACCESS_TIMEOUT_EN with TIMEOUT_CYCLES = 4, no ack on a load -> DONE after 4 WAIT cycles; err_o = 1 and stays 1; ReadData_o = 0.
REQ-042 MemRead_i = MemWrite_i = 1 -> write issued; mem_we_o = 1; no ReadValid_o pulse.
